// File: rtl/clrx_axil_regfile.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C modes, independent AW/W holders,
// SLVERR on out-of-range indices and a registered interrupt from the W1C event bits.
module clrx_axil_regfile #(
  parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned         NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK           = '0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
  output logic [NUM_REGS-1:0]                    wr_pulse_o,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] event_i,
  output logic                                   irq_o
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = AW - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_state_e;

  wr_state_e                   wr_state_q, wr_state_d;
  logic                        aw_held_q, aw_held_d;
  logic [IW-1:0]               aw_idx_q, aw_idx_d;
  logic                        w_held_q, w_held_d;
  logic [DW-1:0]               w_data_q, w_data_d;
  logic [SW-1:0]               w_strb_q, w_strb_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
  logic                        irq_q, irq_d;
  logic                        rvalid_q, rvalid_d;
  logic [DW-1:0]               rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [DW-1:0]               strb_mask_c;
  logic                        aw_hs_c, w_hs_c, ar_hs_c;
  logic                        unused_c;

  assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = !aw_held_q && !bvalid_q;
  assign s00_axi_wready  = !w_held_q && !bvalid_q;
  assign s00_axi_arready = !rvalid_q;
  assign aw_hs_c = s00_axi_awvalid && s00_axi_awready;
  assign w_hs_c  = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs_c = s00_axi_arvalid && s00_axi_arready;

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rresp  = rresp_q;
  assign ctrl_o         = regs_q;
  assign wr_pulse_o     = wr_pulse_q;
  assign irq_o          = irq_q;

  always_comb begin
    strb_mask_c = '0;
    for (int unsigned b = 0; b < SW; b++) strb_mask_c[b*8 +: 8] = {8{w_strb_q[b]}};
  end

  // Write channel: holders fill independently, commit one cycle after both are seen held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[AW-1:2];
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    case (wr_state_q)
      WR_COLLECT: if (aw_held_q && w_held_q) wr_state_d = WR_COMMIT;
      WR_COMMIT: begin
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = RESP_SLVERR;
        wr_state_d = WR_RESP;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (aw_idx_q == IW'(i)) begin
            bresp_d       = RESP_OKAY;
            wr_pulse_d[i] = !RO_MASK[i];
          end
        end
      end
      WR_RESP: if (s00_axi_bready) begin
        bvalid_d   = 1'b0;
        wr_state_d = WR_COLLECT;
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  // Register update; a W1C event set overrides a same-cycle clear.
  always_comb begin
    regs_d = regs_q;
    irq_d  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) begin
        if (wr_state_q == WR_COMMIT && aw_idx_q == IW'(i)) begin
          if (W1C_MASK[i]) regs_d[i] = regs_q[i] & ~(w_data_q & strb_mask_c);
          else             regs_d[i] = (regs_q[i] & ~strb_mask_c) | (w_data_q & strb_mask_c);
        end
        if (W1C_MASK[i]) begin
          regs_d[i] = regs_d[i] | event_i[i*DW +: DW];
          irq_d     = irq_d | (|regs_q[i]);
        end
      end
    end
  end

  // Read channel: data captured at the AR handshake from pre-commit register values.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (s00_axi_araddr[AW-1:2] == IW'(i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = RO_MASK[i] ? status_i[i*DW +: DW] : regs_q[i];
        end
      end
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      regs_q     <= '0;
      irq_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      irq_q      <= irq_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end
endmodule

// File: tb/tb_clrx_axil_regfile.sv
// Self-checking bench for clrx_axil_regfile: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_clrx_axil_regfile;
  localparam int unsigned NR    = 12;
  localparam int unsigned DW    = 32;
  localparam logic [NR-1:0] RO_M  = 12'h030;
  localparam logic [NR-1:0] W1C_M = 12'h0E8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [31:0]      wdata, rdata;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*DW-1:0] ctrl, status_v, event_v;
  logic [NR-1:0]    wr_pulse;
  logic             irq;

  int          vectors = 0;
  int          errors  = 0;
  int          pulse_cnt [NR];
  logic [31:0] mdl [NR];

  clrx_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .ctrl_o(ctrl), .wr_pulse_o(wr_pulse),
    .status_i(status_v), .event_i(event_v), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  // 0 out of range, 1 read-only, 2 write-1-to-clear, 3 read/write
  function automatic int kind(input int idx);
    logic [NR-1:0] ro, wc;
    ro = RO_M;
    wc = W1C_M;
    if (idx >= NR) return 0;
    if (ro[idx]) return 1;
    if (wc[idx]) return 2;
    return 3;
  endfunction

  function automatic logic [NR*DW-1:0] ctrl_exp();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  function automatic logic irq_exp();
    for (int i = 0; i < NR; i++) if (kind(i) == 2 && mdl[i] != 32'h0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    case (kind(idx))
      2:       mdl[idx] = mdl[idx] & ~(d & m);
      3:       mdl[idx] = (mdl[idx] & ~m) | (d & m);
      default: ;
    endcase
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_done, w_done, aw_rdy, w_rdy;
    int   n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_rdy = awready; w_rdy = wready;
      @(posedge clk); #1; n++;
      if (awvalid && aw_rdy) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (wvalid && w_rdy)   begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    resp = bresp;
    if (!bvalid) begin
      vectors++; errors++;
      $display("FAIL write_timeout addr=%h: bvalid never rose", a);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic rdy, done;
    int   n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      rdy = arready;
      @(posedge clk); #1; n++;
      if (rdy) done = 1'b1;
    end
    arvalid = 1'b0;
    d = rdata; resp = rresp;
    if (!rvalid) begin
      vectors++; errors++;
      $display("FAIL read_timeout addr=%h: rvalid not set after AR handshake", a);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ev_pulse(input int idx, input logic [31:0] bits);
    event_v[idx*DW +: DW] = bits;
    @(posedge clk); #1;
    event_v = '0;
    if (kind(idx) == 2) mdl[idx] = mdl[idx] | bits;
    @(posedge clk); #1;
  endtask

  task automatic check_read(input string nm, input int idx, input logic [1:0] lo);
    logic [31:0] d, exp_d;
    logic [1:0]  r, exp_r;
    status_v = {NR{$urandom()}} ^ {(NR*DW/32){$urandom()}};
    exp_r = (kind(idx) == 0) ? 2'b10 : 2'b00;
    exp_d = (kind(idx) == 0) ? 32'h0 : (kind(idx) == 1) ? status_v[idx*DW +: DW] : mdl[idx];
    axi_read({4'(idx), lo}, d, r);
    vectors++;
    if (d !== exp_d || r !== exp_r) begin
      errors++;
      $display("FAIL %s idx=%0d: got data=%h resp=%b, want data=%h resp=%b", nm, idx, d, r, exp_d, exp_r);
    end
  endtask

  task automatic check_state(input string nm);
    vectors++;
    if (ctrl !== ctrl_exp() || irq !== irq_exp()) begin
      errors++;
      $display("FAIL %s: ctrl=%h irq=%b, want ctrl=%h irq=%b", nm, ctrl, irq, ctrl_exp(), irq_exp());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 3'b010; arprot = 3'b101;
    status_v = '0; event_v = '0;
    for (int i = 0; i < NR; i++) begin mdl[i] = 32'h0; pulse_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || ctrl !== '0 || irq !== 1'b0 || wr_pulse !== '0) begin
      errors++;
      $display("FAIL reset_outputs: bvalid=%b rvalid=%b irq=%b pulse=%h, want all 0", bvalid, rvalid, irq, wr_pulse);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: aw/w/ar ready=%b, want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4 * i), 32'(i + 1), 4'hF, r);
      model_write(i, 32'(i + 1), 4'hF);
      vectors++;
      if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp idx=%0d: got %b want 00", i, r); end
    end
    for (int i = 0; i < 4; i++) check_read("basic_read", i, 2'b00);
  endtask

  task automatic test_wstrb();
    logic [1:0] r;
    axi_write(6'h00, 32'h11223344, 4'hF, r);
    model_write(0, 32'h11223344, 4'hF);
    axi_write(6'h02, 32'hAABBCCDD, 4'b0010, r);
    model_write(0, 32'hAABBCCDD, 4'b0010);
    vectors++;
    if (mdl[0] !== 32'h1122CC44 || ctrl[31:0] !== 32'h1122CC44) begin
      errors++;
      $display("FAIL wstrb: got %h want 1122cc44", ctrl[31:0]);
    end
    check_read("wstrb_read", 0, 2'b01);
  endtask

  task automatic test_w_before_aw();
    logic rdy;
    int   p0;
    p0 = pulse_cnt[1];
    awaddr = 6'h04; wdata = 32'hCAFE0001; wstrb = 4'hF; bready = 1'b1; wvalid = 1'b1;
    rdy = wready;
    @(posedge clk); #1;
    wvalid = 1'b0;
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL wfirst_wready: got %b want 1", rdy); end
    repeat (3) @(posedge clk);
    #1;
    awvalid = 1'b1;
    rdy = awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rdy !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL wfirst_early: awready=%b bvalid=%b, want 1 0", rdy, bvalid);
    end
    @(posedge clk); #1;
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL wfirst_bvalid: bvalid=%b bresp=%b, want 1 00", bvalid, bresp);
    end
    @(posedge clk); #1;
    model_write(1, 32'hCAFE0001, 4'hF);
    vectors++;
    if (pulse_cnt[1] !== p0 + 1) begin
      errors++; $display("FAIL wfirst_pulse: got %0d pulses want 1", pulse_cnt[1] - p0);
    end
    check_state("wfirst_state");
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    int         ptot;
    ptot = 0;
    for (int i = 0; i < NR; i++) ptot += pulse_cnt[i];
    axi_write(6'(4 * NR), 32'hFFFFFFFF, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b want 10", r); end
    for (int i = 0; i < NR; i++) ptot -= pulse_cnt[i];
    vectors++;
    if (ptot !== 0) begin errors++; $display("FAIL oor_pulse: got %0d pulses want 0", -ptot); end
    check_state("oor_state");
    check_read("oor_read", NR, 2'b00);
  endtask

  task automatic test_w1c();
    logic [1:0] r;
    ev_pulse(3, 32'h8);
    check_read("w1c_set_read", 3, 2'b00);
    check_state("w1c_set_state");
    axi_write(6'h0C, 32'h8, 4'hF, r);
    model_write(3, 32'h8, 4'hF);
    check_read("w1c_clr_read", 3, 2'b00);
    check_state("w1c_clr_state");
    // clear commits on the same edge the event bit is sampled
    awaddr = 6'h0C; wdata = 32'h8; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    event_v[3*DW +: DW] = 32'h8;
    @(posedge clk); #1;
    event_v = '0;
    vectors++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL w1c_race_align: bvalid=%b want 1", bvalid); end
    @(posedge clk); #1;
    mdl[3] = 32'h8;
    check_read("w1c_race_read", 3, 2'b00);
    check_state("w1c_race_state");
  endtask

  task automatic test_random();
    logic [1:0]  r, exp_r;
    logic [31:0] d;
    logic [3:0]  s;
    int          idx, p0, k;
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          idx = int'($urandom_range(0, 15));
          d = $urandom(); s = 4'($urandom_range(0, 15));
          k = kind(idx);
          p0 = (idx < NR) ? pulse_cnt[idx] : 0;
          axi_write({4'(idx), 2'($urandom_range(0, 3))}, d, s, r);
          model_write(idx, d, s);
          exp_r = (k == 0) ? 2'b10 : 2'b00;
          vectors++;
          if (r !== exp_r || (idx < NR && pulse_cnt[idx] !== p0 + ((k >= 2) ? 1 : 0))) begin
            errors++;
            $display("FAIL rnd_write idx=%0d: bresp=%b want %b", idx, r, exp_r);
          end
          check_state("rnd_write_state");
        end
        1: check_read("rnd_read", int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        default: begin
          ev_pulse(int'($urandom_range(0, NR - 1)), $urandom() & $urandom());
          check_state("rnd_event_state");
        end
      endcase
    end
  endtask

  task automatic test_bready_hold_reset();
    awaddr = 6'h08; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = 6'h10;
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL bhold cyc=%0d: bvalid=%b bresp=%b awready=%b wready=%b, want 1 00 0 0",
                 c, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    vectors++;
    if (bvalid !== 1'b0 || ctrl !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: bvalid=%b irq=%b ctrl=%h, want 0 0 0", bvalid, irq, ctrl);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_read("post_reset_read", 2, 2'b00);
    check_state("post_reset_state");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wstrb();
    test_w_before_aw();
    test_out_of_range();
    test_w1c();
    test_random();
    test_bready_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
